// File: rtl/rom_sample_player.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : rom_sample_player                                           |
// | Purpose  : Playback sequencer in front of the music sample ROM. Steps  |
// |            the ROM address once per sample period, registers each     |
// |            returned word and offers it downstream over valid/ready.   |
// |            Supports start/stop, one-shot or looped playback, and a    |
// |            sticky underrun flag for samples the consumer did not take |
// |            before the next sample period.                             |
// | Ports    : i_CLK / i_RESET      clock, async active-low reset          |
// |            i_Start / i_Stop     begin playback at 0 / abort playback   |
// |            i_Loop               wrap to address 0 after last sample    |
// |            o_ROM_Enable/Address ROM strobe (FETCH only) and address    |
// |            i_ROM_Data           combinational ROM read data           |
// |            o_Sample/o_Valid     sample to the consumer                |
// |            i_Ready              consumer accept                       |
// |            o_Busy/o_Done        not idle / one-shot completion pulse  |
// |            o_Underrun           sticky late-consumer flag             |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module rom_sample_player #(
  parameter int AddressWidth = 16,
  parameter int WordWidth    = 16,
  parameter int MemorySize   = 256,
  parameter int ClockDivider = 6250
) (
  input  logic                    i_CLK,
  input  logic                    i_RESET,
  input  logic                    i_Start,
  input  logic                    i_Stop,
  input  logic                    i_Loop,
  output logic                    o_ROM_Enable,
  output logic [AddressWidth-1:0] o_ROM_Address,
  input  logic [WordWidth-1:0]    i_ROM_Data,
  output logic [WordWidth-1:0]    o_Sample,
  output logic                    o_Valid,
  input  logic                    i_Ready,
  output logic                    o_Busy,
  output logic                    o_Done,
  output logic                    o_Underrun
);

  localparam int                      c_DIV_W     = $clog2(ClockDivider);
  localparam logic [c_DIV_W-1:0]      c_DIV_LAST  = c_DIV_W'(ClockDivider - 1);
  localparam logic [AddressWidth-1:0] c_ADDR_LAST = AddressWidth'(MemorySize - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_OUTPUT = 2'd2,
    S_WAIT   = 2'd3
  } state_t;

  state_t                  r_state;
  logic [c_DIV_W-1:0]      r_div;
  logic                    r_rom_enable;
  logic [AddressWidth-1:0] r_address;
  logic [WordWidth-1:0]    r_sample;
  logic                    r_valid;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_underrun;

  logic w_tick;
  logic w_handshake;

  // The sample-period tick only exists while playing; the divider is parked
  // at zero in IDLE so every playback starts on a fresh period.
  assign w_tick      = (r_state != S_IDLE) && (r_div == c_DIV_LAST);
  assign w_handshake = r_valid && i_Ready;

  always_ff @(posedge i_CLK or negedge i_RESET) begin
    if (!i_RESET) begin
      r_state      <= S_IDLE;
      r_div        <= '0;
      r_rom_enable <= 1'b0;
      r_address    <= '0;
      r_sample     <= '0;
      r_valid      <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_underrun   <= 1'b0;
    end else begin
      r_done <= 1'b0;

      if (r_state == S_IDLE) begin
        r_div <= '0;
      end else if (w_tick) begin
        r_div <= '0;
      end else begin
        r_div <= r_div + 1'b1;
      end

      // Stop outranks start and any handshake in the same cycle; the
      // underrun flag is deliberately left alone so it can be inspected.
      if (i_Stop) begin
        r_state      <= S_IDLE;
        r_div        <= '0;
        r_address    <= '0;
        r_valid      <= 1'b0;
        r_rom_enable <= 1'b0;
        r_busy       <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (i_Start) begin
              r_state      <= S_FETCH;
              r_address    <= '0;
              r_div        <= '0;
              r_underrun   <= 1'b0;
              r_rom_enable <= 1'b1;
              r_busy       <= 1'b1;
            end
          end

          S_FETCH: begin
            r_sample     <= i_ROM_Data;
            r_valid      <= 1'b1;
            r_rom_enable <= 1'b0;
            r_state      <= S_OUTPUT;
          end

          S_OUTPUT: begin
            if (w_handshake) begin
              r_valid <= 1'b0;
              if (r_address != c_ADDR_LAST) begin
                r_address <= r_address + 1'b1;
                r_state   <= S_WAIT;
              end else if (i_Loop) begin
                r_address <= '0;
                r_state   <= S_WAIT;
              end else begin
                r_address <= '0;
                r_div     <= '0;
                r_busy    <= 1'b0;
                r_done    <= 1'b1;
                r_state   <= S_IDLE;
              end
            end else if (w_tick) begin
              // Sample still pending when the next period starts: flag it,
              // keep presenting it, and fetch only after a later tick.
              r_underrun <= 1'b1;
            end
          end

          S_WAIT: begin
            if (w_tick) begin
              r_state      <= S_FETCH;
              r_rom_enable <= 1'b1;
            end
          end

          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign o_ROM_Enable  = r_rom_enable;
  assign o_ROM_Address = r_address;
  assign o_Sample      = r_sample;
  assign o_Valid       = r_valid;
  assign o_Busy        = r_busy;
  assign o_Done        = r_done;
  assign o_Underrun    = r_underrun;

endmodule
`default_nettype wire
